lcd_result_formatter: RTL and testbench
=======================================

Name: lcd_result_formatter

Overview:
Downstream consumer of the 16-bit adder stage. It captures the sum on the rising edge of show_result and converts it to five decimal digits with a sequential double-dabble (one shift per clock). It then streams one LCD cursor-address command followed by five ASCII characters to the LCD writer over a valid/ready handshake.

Parameters:
LINE_ADDR, 8'h40, DDRAM address of the first result character; the command byte emitted is 8'h80 | LINE_ADDR.
LEADING_ZERO_BLANK, 1, 1 = replace leading zero digits with FILL_CHAR; 0 = print all five digits.
FILL_CHAR, 8'h20, character used for blanked leading zeros.

Ports:
clk  input  1  system clock, all logic rising-edge.
reset  input  1  synchronous, active-high.
result  input  16  unsigned sum from the adder stage.
show_result  input  1  level from the adder stage; a rising edge requests display.
char_data  output  8  command or ASCII byte presented to the LCD writer.
char_is_cmd  output  1  1 = char_data is an LCD command; 0 = display data.
char_valid  output  1  char_data/char_is_cmd are valid.
char_ready  input  1  LCD writer accepts the byte this cycle when high together with char_valid.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse after the last character is accepted.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - char_data = 0, char_is_cmd = 0, char_valid = 0, busy = 0, done = 0.
  - show_prev = 0, bit counter = 0, char index = 0, BCD register = 0.
- Edge detect: show_prev <= show_result every cycle. Trigger = show_result & ~show_prev, evaluated only in IDLE.
- A trigger outside IDLE is dropped, not queued. A level held high never retriggers.
- IDLE: on trigger at cycle N, latch result into the binary shift register, clear the 20-bit BCD register, go to CONVERT.
- CONVERT: runs cycles N+1..N+16, one iteration per cycle.
  - Each iteration: every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1.
  - After the 16th iteration, go to SEND_CMD.
- SEND_CMD: first valid at cycle N+17.
  - char_valid = 1, char_is_cmd = 1, char_data = 8'h80 | LINE_ADDR.
  - Held stable until char_valid & char_ready, then go to SEND_CHAR with index 0.
- SEND_CHAR: indexes 0..4 emit ten-thousands down to units, char_is_cmd = 0.
  - A digit d is sent as 8'h30 + d.
  - With LEADING_ZERO_BLANK = 1, a zero digit with all higher digits zero is sent as FILL_CHAR. The units digit is never blanked.
  - char_data is computed from index and the BCD register and held stable while char_ready = 0.
  - On each handshake the index increments. Back-to-back transfers are allowed (char_valid stays 1).
  - On the handshake at index 4, go to DONE.
- DONE: char_valid = 0, done = 1 for exactly one cycle, then IDLE.
- Minimum trigger-to-done with char_ready tied high: command accepted N+17, characters N+18..N+22, done at N+23.
- char_valid is never asserted outside SEND_CMD/SEND_CHAR. Data never changes while valid is high and ready is low.
- Reset mid-operation in any state:
  - Abort next cycle, return to IDLE, drop char_valid with no further bytes.
  - If show_result is high on the first cycle after reset, that counts as a rising edge (show_prev = 0) and starts a new conversion.
- Input range: 0..65535, so five digits always suffice. The adder's wrap-around is not this block's concern.

Test Plan:
- result = 16'd1234, pulse show_result, char_ready = 1 -> bytes 8'hC0 (cmd), then ' ','1','2','3','4' (20,31,32,33,34); done at trigger + 23 cycles.
- result = 0 -> 8'hC0, then 20,20,20,20,30. result = 65535 -> 36,35,35,33,35. result = 100 -> 20,20,31,30,30.
- result = 16'd1234, char_ready low for 3 cycles at each byte -> char_data/char_is_cmd stable while stalled, same byte sequence, no duplicates, done delayed by 18 cycles.
- show_result held high for 100 cycles, plus a second rising edge while busy -> exactly one command + 5 characters, one done pulse.
- Reset asserted during SEND_CHAR index 2 -> char_valid = 0 the next cycle, busy = 0, no done pulse. A new trigger then produces a full, correct sequence.
- LEADING_ZERO_BLANK = 0, LINE_ADDR = 8'h00, result = 42 -> 8'h80, then 30,30,30,34,32.

Source files
------------

// File: rtl/lcd_result_formatter_if.sv
// rtl/lcd_result_formatter_if.sv - byte stream from result formatter to LCD writer
interface lcd_result_formatter_if;
  logic [7:0] char_data;
  logic       char_is_cmd;
  logic       char_valid;
  logic       char_ready;

  modport master (
    output char_data,
    output char_is_cmd,
    output char_valid,
    input  char_ready
  );

  modport slave (
    input  char_data,
    input  char_is_cmd,
    input  char_valid,
    output char_ready
  );
endinterface

// File: rtl/lcd_result_formatter.sv
// rtl/lcd_result_formatter.sv - binary sum to five-digit LCD byte stream
module lcd_result_formatter #(
  parameter logic [7:0] LINE_ADDR          = 8'h40,
  parameter bit         LEADING_ZERO_BLANK = 1'b1,
  parameter logic [7:0] FILL_CHAR          = 8'h20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   result,
  input  logic                          show_result,
  lcd_result_formatter_if.master        char_if,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    SEND_CMD,
    SEND_CHAR,
    DONE_ST
  } state_t;

  state_t      state;
  logic        show_prev;
  logic [15:0] bin_reg;
  logic [19:0] bcd_reg;
  logic [3:0]  bit_cnt;
  logic [2:0]  char_idx;
  logic [19:0] bcd_adj;
  logic [35:0] shifted;
  logic        trigger;

  assign trigger = show_result & ~show_prev;

  // Character for digit position idx (0 = ten-thousands .. 4 = units),
  // blanking leading zeros above the units digit when enabled.
  function automatic logic [7:0] digit_char(input logic [19:0] bcd, input logic [2:0] idx);
    logic [7:0] ch;
    logic [3:0] nib;
    logic       higher_zero;
    ch          = 8'h30;
    higher_zero = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nib = bcd[(4 - i) * 4 +: 4];
      if (i == int'(idx)) begin
        if (LEADING_ZERO_BLANK && (i < 4) && higher_zero && (nib == 4'd0))
          ch = FILL_CHAR;
        else
          ch = {4'h3, nib};
      end
      higher_zero = higher_zero & (nib == 4'd0);
    end
    return ch;
  endfunction

  // Double-dabble add-3 correction on every BCD nibble before the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 5; i++) begin
      if (bcd_reg[i * 4 +: 4] >= 4'd5)
        bcd_adj[i * 4 +: 4] = bcd_reg[i * 4 +: 4] + 4'd3;
      else
        bcd_adj[i * 4 +: 4] = bcd_reg[i * 4 +: 4];
    end
  end

  assign shifted = {bcd_adj, bin_reg} << 1;

  // Control FSM with registered stream, busy and done outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      show_prev           <= 1'b0;
      bin_reg             <= '0;
      bcd_reg             <= '0;
      bit_cnt             <= '0;
      char_idx            <= '0;
      char_if.char_data   <= '0;
      char_if.char_is_cmd <= 1'b0;
      char_if.char_valid  <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      show_prev <= show_result;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (trigger) begin
            bin_reg <= result;
            bcd_reg <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= CONVERT;
          end
        end

        CONVERT: begin
          bcd_reg <= shifted[35:16];
          bin_reg <= shifted[15:0];
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            char_if.char_valid  <= 1'b1;
            char_if.char_is_cmd <= 1'b1;
            char_if.char_data   <= 8'h80 | LINE_ADDR;
            state               <= SEND_CMD;
          end
        end

        SEND_CMD: begin
          if (char_if.char_valid && char_if.char_ready) begin
            char_idx            <= 3'd0;
            char_if.char_is_cmd <= 1'b0;
            char_if.char_data   <= digit_char(bcd_reg, 3'd0);
            state               <= SEND_CHAR;
          end
        end

        SEND_CHAR: begin
          if (char_if.char_valid && char_if.char_ready) begin
            if (char_idx == 3'd4) begin
              char_if.char_valid <= 1'b0;
              done               <= 1'b1;
              state              <= DONE_ST;
            end else begin
              char_idx          <= char_idx + 3'd1;
              char_if.char_data <= digit_char(bcd_reg, char_idx + 3'd1);
            end
          end
        end

        DONE_ST: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          char_if.char_valid <= 1'b0;
          busy               <= 1'b0;
          done               <= 1'b0;
          state              <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_result_formatter.sv
// tb/tb_lcd_result_formatter.sv - directed bench for lcd_result_formatter
module tb_lcd_result_formatter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] result = '0;
  logic [15:0] result2 = '0;
  logic        show = 1'b0;
  logic        show2 = 1'b0;
  logic        busy, done, busy2, done2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;
  int stall_cnt = 0;
  int done_cnt = 0;
  int done2_cnt = 0;
  logic [8:0] q1[$];
  logic [8:0] q2[$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_byte = '0;

  lcd_result_formatter_if if1();
  lcd_result_formatter_if if2();

  assign if2.char_ready = 1'b1;

  always #5 clk = ~clk;

  lcd_result_formatter dut (
    .clk(clk), .reset(reset), .result(result), .show_result(show),
    .char_if(if1.master), .busy(busy), .done(done)
  );

  lcd_result_formatter #(.LINE_ADDR(8'h00), .LEADING_ZERO_BLANK(1'b0), .FILL_CHAR(8'h20)) dut2 (
    .clk(clk), .reset(reset), .result(result2), .show_result(show2),
    .char_if(if2.master), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Ready driver: mode 0 always ready, mode 1 stalls three cycles per byte.
  always @(posedge clk) begin
    #1;
    if (mode == 1) begin
      if (if1.char_valid) begin
        if (stall_cnt < 3) begin
          if1.char_ready = 1'b0;
          stall_cnt++;
        end else begin
          if1.char_ready = 1'b1;
          stall_cnt = 0;
        end
      end else begin
        if1.char_ready = 1'b0;
        stall_cnt = 0;
      end
    end else begin
      if1.char_ready = 1'b1;
    end
  end

  // Monitor: records accepted bytes, done pulses, hold stability while stalled.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (done2) done2_cnt++;
    if (!reset) begin
      if (prev_stall) begin
        check("hold_data", {if1.char_is_cmd, if1.char_data}, prev_byte);
        check("hold_valid", if1.char_valid, 1'b1);
      end
      if (if1.char_valid) check("valid_implies_busy", busy, 1'b1);
      if (if1.char_valid && if1.char_ready) q1.push_back({if1.char_is_cmd, if1.char_data});
      if (if2.char_valid && if2.char_ready) q2.push_back({if2.char_is_cmd, if2.char_data});
      prev_stall = if1.char_valid && !if1.char_ready;
      prev_byte  = {if1.char_is_cmd, if1.char_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic run_seq(input string tag, input logic [15:0] r, input int m,
                         input logic [47:0] exp, input int exp_lat);
    int c0, dc0, lat;
    logic [7:0] eb;
    @(posedge clk); #2;
    mode = m;
    result = r;
    q1.delete();
    dc0 = done_cnt;
    c0 = cyc;
    show = 1'b1;
    @(posedge clk); #2;
    show = 1'b0;
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - c0;
        break;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_count"}, q1.size(), 6);
    for (int i = 0; i < 6 && i < q1.size(); i++) begin
      eb = exp[47 - 8 * i -: 8];
      check({tag, "_byte"}, q1[i], {(i == 0), eb});
    end
    repeat (3) @(posedge clk);
    #2;
    check({tag, "_done_pulses"}, done_cnt - dc0, 1);
    check({tag, "_idle_busy"}, busy, 1'b0);
    mode = 0;
  endtask

  initial begin
    int dc0, c0, lat;
    logic found;
    logic [47:0] exp2;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", if1.char_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_data", if1.char_data, 8'h00);
    check("rst_is_cmd", if1.char_is_cmd, 1'b0);
    reset = 1'b0;

    run_seq("r1234", 16'd1234, 0, 48'hC0_20_31_32_33_34, 23);
    run_seq("r0", 16'd0, 0, 48'hC0_20_20_20_20_30, 23);
    run_seq("r65535", 16'd65535, 0, 48'hC0_36_35_35_33_35, 23);
    run_seq("r100", 16'd100, 0, 48'hC0_20_20_31_30_30, 23);
    run_seq("stall1234", 16'd1234, 1, 48'hC0_20_31_32_33_34, 41);

    // Level held high with an extra rising edge while busy.
    @(posedge clk); #2;
    q1.delete();
    dc0 = done_cnt;
    result = 16'd777;
    show = 1'b1;
    repeat (5) @(posedge clk);
    #2 show = 1'b0;
    @(posedge clk); #2;
    check("hold_busy_at_retrigger", busy, 1'b1);
    show = 1'b1;
    repeat (94) @(posedge clk);
    #2 show = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("hold_count", q1.size(), 6);
    check("hold_done_pulses", done_cnt - dc0, 1);
    if (q1.size() == 6) begin
      check("hold_first", q1[0], 9'h1C0);
      check("hold_last", q1[5], 9'h037);
    end

    // Reset during SEND_CHAR index 2.
    @(posedge clk); #2;
    q1.delete();
    dc0 = done_cnt;
    result = 16'd1234;
    show = 1'b1;
    @(posedge clk); #2;
    show = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (if1.char_valid && !if1.char_is_cmd && if1.char_data == 8'h32) begin
        found = 1'b1;
        break;
      end
    end
    check("rstmid_reached_idx2", found, 1'b1);
    reset = 1'b1;
    check("rstmid_bytes_before", q1.size(), 3);
    @(posedge clk); #2;
    check("rstmid_valid", if1.char_valid, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    check("rstmid_no_done", done_cnt - dc0, 0);
    check("rstmid_no_more_bytes", q1.size(), 3);
    run_seq("after_rst", 16'd1234, 0, 48'hC0_20_31_32_33_34, 23);

    // No blanking, line address 0.
    @(posedge clk); #2;
    q2.delete();
    dc0 = done2_cnt;
    c0 = cyc;
    result2 = 16'd42;
    show2 = 1'b1;
    @(posedge clk); #2;
    show2 = 1'b0;
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done2) begin
        lat = cyc - c0;
        break;
      end
    end
    check("r42_latency", lat, 23);
    check("r42_count", q2.size(), 6);
    exp2 = 48'h80_30_30_30_34_32;
    for (int i = 0; i < 6 && i < q2.size(); i++)
      check("r42_byte", q2[i], {(i == 0), exp2[47 - 8 * i -: 8]});
    repeat (3) @(posedge clk);
    #2;
    check("r42_done_pulses", done2_cnt - dc0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
